laser_serial_tx: RTL

Reader-side partner of the transmit byte queue. Pops one byte at a time over the queue's read/empty handshake and serialises it onto the laser drive pin as a fixed-rate on-off-keyed frame. Sits between the 16-bit-in/8-bit-out transmit queue and the laser driver output pin.

---
 rtl/laser_serial_tx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/laser_serial_tx.sv
// On-off-keyed serial transmitter: pops bytes from the transmit queue and sends START, 8 data bits LSB first, STOP.
// Optional even-parity bit before STOP when LASER_TX_PARITY_EN is defined.
module laser_serial_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [7:0]         q_data,
  input  logic               q_empty,
  output logic               q_read,
  output logic               laser_out,
  output logic               busy,
  output logic               frame_done,
  output logic [COUNT_W-1:0] bytes_sent
);

`ifdef LASER_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [7:0] LAST_CYCLE = 8'(CLKS_PER_BIT - 1);

  state_t               r_state, w_state_next;
  logic [7:0]           r_cycle, w_cycle_next;
  logic [2:0]           r_bit, w_bit_next;
  logic [7:0]           r_shift, w_shift_next;
  logic                 r_laser, w_laser_next;
  logic [COUNT_W-1:0]   r_bytes, w_bytes_next;
  logic                 w_last;
  logic                 w_load;
`ifdef LASER_TX_PARITY_EN
  logic                 r_parity, w_parity_next;
`endif

  assign w_last     = (r_cycle == LAST_CYCLE);
  assign laser_out  = r_laser;
  assign busy       = (r_state != S_IDLE);
  assign bytes_sent = r_bytes;

  always_comb begin
    w_state_next = r_state;
    w_cycle_next = r_cycle + 8'd1;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_laser_next = r_laser;
    w_bytes_next = r_bytes;
    q_read       = 1'b0;
    frame_done   = 1'b0;
    w_load       = 1'b0;

    if (clear) begin
      w_state_next = S_IDLE;
      w_cycle_next = 8'd0;
      w_bit_next   = 3'd0;
      w_shift_next = 8'd0;
      w_laser_next = 1'b0;
      w_bytes_next = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cycle_next = 8'd0;
          w_laser_next = 1'b0;
          w_load       = enable && !q_empty;
        end
        S_START: begin
          if (w_last) begin
            w_state_next = S_DATA;
            w_cycle_next = 8'd0;
            w_bit_next   = 3'd0;
            w_laser_next = r_shift[0];
          end
        end
        S_DATA: begin
          if (w_last) begin
            w_cycle_next = 8'd0;
            if (r_bit == 3'd7) begin
`ifdef LASER_TX_PARITY_EN
              w_state_next = S_PARITY;
              w_laser_next = r_parity;
`else
              w_state_next = S_STOP;
              w_laser_next = 1'b0;
`endif
            end else begin
              // Register the next bit's level so laser_out changes exactly at the bit boundary.
              w_bit_next   = r_bit + 3'd1;
              w_shift_next = r_shift >> 1;
              w_laser_next = r_shift[1];
            end
          end
        end
`ifdef LASER_TX_PARITY_EN
        S_PARITY: begin
          if (w_last) begin
            w_state_next = S_STOP;
            w_cycle_next = 8'd0;
            w_laser_next = 1'b0;
          end
        end
`endif
        S_STOP: begin
          if (w_last) begin
            frame_done   = 1'b1;
            w_bytes_next = r_bytes + 1'b1;
            w_cycle_next = 8'd0;
            w_state_next = S_IDLE;
            w_load       = enable && !q_empty;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cycle_next = 8'd0;
          w_laser_next = 1'b0;
        end
      endcase

      // A pop starts the next frame with zero gap, from IDLE or the last STOP cycle.
      if (w_load) begin
        q_read       = 1'b1;
        w_shift_next = q_data;
        w_state_next = S_START;
        w_cycle_next = 8'd0;
        w_bit_next   = 3'd0;
        w_laser_next = 1'b1;
      end
    end
  end

`ifdef LASER_TX_PARITY_EN
  assign w_parity_next = clear ? 1'b0 : (w_load ? ^q_data : r_parity);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_parity <= 1'b0;
    else       r_parity <= w_parity_next;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cycle <= 8'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_laser <= 1'b0;
      r_bytes <= '0;
    end else begin
      r_state <= w_state_next;
      r_cycle <= w_cycle_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_laser <= w_laser_next;
      r_bytes <= w_bytes_next;
    end
  end

endmodule
